// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word accesses onto a word-wide data
// memory, splitting misaligned accesses across two words and faulting bad ones.
module lsu_align #(
  parameter int unsigned SIZE_POW2 = 9,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic        dm_we,
  output logic [3:0]  dm_byte_en,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam logic [31:0] MEM_BYTES = 32'd1 << SIZE_POW2;
  localparam logic [31:0] LIMIT     = BASE_ADDR + MEM_BYTES - 32'd1;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;

  // Access width in bytes (1, 2 or 4); illegal codes fall back to word.
  function automatic logic [2:0] dec_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   dec_size = 3'd1;
      2'b01:   dec_size = 3'd2;
      default: dec_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] size);
    case (size)
      3'd1:    mask_of = 4'b0001;
      3'd2:    mask_of = 4'b0011;
      default: mask_of = 4'b1111;
    endcase
  endfunction

  // funct3[2] selects zero extension for byte/half loads.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = {{24{raw[7] & ~f3[2]}}, raw[7:0]};
      2'b01:   extend = {{16{raw[15] & ~f3[2]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic        legal;
  logic [2:0]  size_w;
  logic [1:0]  size_m1;
  logic [1:0]  off;
  logic [2:0]  off_plus_size;
  logic [32:0] last_ext;
  logic [31:0] last;
  logic        in_range;
  logic        fault;
  logic        split;
  logic [4:0]  sh_lo;
  logic [3:0]  be_single;

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign size_w        = dec_size(funct3);
  assign size_m1       = 2'(size_w - 3'd1);
  assign off           = addr[1:0];
  assign off_plus_size = {1'b0, off} + size_w;
  assign split         = off_plus_size > 3'd4;
  assign sh_lo         = {off, 3'b000};

  // The carry out of the 33-bit sum flags a last byte that wrapped past 2^32.
  assign last_ext = {1'b0, addr} + {31'b0, size_m1};
  assign last     = last_ext[31:0];
  assign in_range = !last_ext[32]
                    && (addr >= BASE_ADDR) && (addr <= LIMIT)
                    && (last >= BASE_ADDR) && (last <= LIMIT);
  assign fault    = !legal || !in_range;

  // Byte lanes touched by a non-split access: lanes off .. off+size-1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_single[gi] = (3'(gi) >= {1'b0, off}) && (3'(gi) < off_plus_size);
    end
  endgenerate

  // Second-part geometry, derived only from the registered request.
  logic [2:0]  rem_q;
  logic [5:0]  sh_hi;
  logic [31:0] word2_addr;

  assign rem_q      = 3'd4 - {1'b0, addr_q[1:0]};
  assign sh_hi      = {rem_q, 3'b000};
  assign word2_addr = {addr_q[31:2], 2'b00} + 32'd4;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    rdata      = 32'd0;
    done       = 1'b0;
    stall      = 1'b0;
    err        = 1'b0;
    dm_we      = 1'b0;
    dm_byte_en = 4'b0000;
    dm_addr    = 32'd0;
    dm_wd      = 32'd0;

    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          dm_addr = {addr[31:2], 2'b00};
          if (req) begin
            if (fault) begin
              err  = 1'b1;
              done = 1'b1;
            end else if (!split) begin
              dm_we      = is_store;
              dm_byte_en = be_single;
              dm_wd      = wdata << sh_lo;
              done       = 1'b1;
              if (!is_store) begin
                rdata = extend(dm_rd >> sh_lo, funct3);
              end
            end else begin
              dm_we      = is_store;
              dm_byte_en = 4'b1111 << off;
              dm_wd      = wdata << sh_lo;
              stall      = 1'b1;
              addr_d     = addr;
              funct3_d   = funct3;
              store_d    = is_store;
              wdata_d    = wdata;
              lo_d       = dm_rd >> sh_lo;
              state_d    = SECOND;
            end
          end
        end
        SECOND: begin
          dm_addr    = word2_addr;
          dm_we      = store_q;
          dm_byte_en = mask_of(dec_size(funct3_q)) >> rem_q;
          dm_wd      = wdata_q >> sh_hi;
          done       = 1'b1;
          if (!store_q) begin
            rdata = extend(lo_q | (dm_rd << sh_hi), funct3_q);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      store_q  <= 1'b0;
      wdata_q  <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a table of single-cycle accesses plus
// hand-written split, reset-abort and reset-release sequences.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        err;
  logic        dm_we;
  logic [3:0]  dm_byte_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  int n_vec = 0;
  int n_err = 0;

  lsu_align #(.SIZE_POW2(9), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .err(err), .dm_we(dm_we), .dm_byte_en(dm_byte_en), .dm_addr(dm_addr),
    .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_done, input logic e_stall,
                         input logic e_err, input logic e_we, input logic [3:0] e_be);
    chk({tag, ".done"},  {31'd0, done},  {31'd0, e_done});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    chk({tag, ".err"},   {31'd0, err},   {31'd0, e_err});
    chk({tag, ".we"},    {31'd0, dm_we}, {31'd0, e_we});
    chk({tag, ".be"},    {28'd0, dm_byte_en}, {28'd0, e_be});
  endtask

  task automatic drive(input logic r, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    req = r; is_store = st; funct3 = f3; addr = a; wdata = wd; dm_rd = rd;
  endtask

  typedef struct {
    logic        req;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e_done;
    logic        e_stall;
    logic        e_err;
    logic        e_we;
    logic [3:0]  e_be;
    logic        chk_rd;
    logic [31:0] e_rdata;
    logic        chk_dm;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // req st f3 addr wdata dm_rd | done stall err we be | chk_rd rdata | chk_dm dm_addr dm_wd
    tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8012_3456,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 32'hFFFF_FF80, 1'b1, 32'h8000_0000, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h8012_3456,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h0000_0080, 1'b1, 32'h8000_0000, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 32'hFFFF_8001, 1'b1, 32'h8000_0000, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1, 32'h0000_8001, 1'b1, 32'h8000_0000, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h8000_0010, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b000, 32'h8000_0005, 32'h0000_00A5, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'h0000_A500});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'hBEEF_0000});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h8000_01FC, 32'h0, 32'h1234_5678,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 32'h1234_5678, 1'b1, 32'h8000_01FC, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h8000_01FF, 32'h0, 32'h7F00_0000,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 32'h0000_007F, 1'b1, 32'h8000_01FC, 32'h0});
    // faults: top-of-memory word, illegal codes, below base, wrap, split past end
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h8000_01FE, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b101, 32'h8000_0000, 32'h55, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b111, 32'h8000_0000, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 32'h8000_01FF, 32'h1234, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    // idle cycle
    tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});

    // Reset: outputs quiet even with a valid store presented.
    rst = 1'b1;
    drive(1'b1, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk); #1;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("rst.rdata", rdata, 32'h0);
    $display("reset cycle: done=%b we=%b be=%b", done, dm_we, dm_byte_en);
    @(posedge clk);
    // First request is accepted in the cycle reset drops.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ctl("rel", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
    chk("rel.addr", dm_addr, 32'h8000_0004);
    $display("release cycle: done=%b we=%b addr=%h", done, dm_we, dm_addr);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd);
      #1;
      chk_ctl($sformatf("v%0d", i), tbl[i].e_done, tbl[i].e_stall, tbl[i].e_err,
              tbl[i].e_we, tbl[i].e_be);
      if (tbl[i].chk_rd) chk($sformatf("v%0d.rdata", i), rdata, tbl[i].e_rdata);
      if (tbl[i].chk_dm) begin
        chk($sformatf("v%0d.addr", i), dm_addr, tbl[i].e_addr);
        chk($sformatf("v%0d.wd", i), dm_wd, tbl[i].e_wd);
      end
      $display("vec %0d: addr=%h f3=%b st=%b done=%b err=%b be=%b rdata=%h",
               i, tbl[i].addr, tbl[i].f3, tbl[i].st, done, err, dm_byte_en, rdata);
    end

    // Split SW at off 2; inputs change during SECOND and must be ignored.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h8000_0006, 32'h1122_3344, 32'h0);
    #1;
    chk_ctl("sw2.p1", 1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
    chk("sw2.p1.addr", dm_addr, 32'h8000_0004);
    chk("sw2.p1.wd", dm_wd, 32'h3344_0000);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b000, 32'h8000_0100, 32'hFFFF_FFFF, 32'h0);
    #1;
    chk_ctl("sw2.p2", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011);
    chk("sw2.p2.addr", dm_addr, 32'h8000_0008);
    chk("sw2.p2.wd", dm_wd, 32'h0000_1122);
    $display("split SW 0x80000006: part2 addr=%h be=%b wd=%h", dm_addr, dm_byte_en, dm_wd);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h0);
    #1;
    chk_ctl("sw2.after", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Split LH at off 3 with sign extension.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b001, 32'h8000_000B, 32'h0, 32'hAB00_0000);
    #1;
    chk_ctl("lh3.p1", 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
    chk("lh3.p1.addr", dm_addr, 32'h8000_0008);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_00CD);
    #1;
    chk_ctl("lh3.p2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    chk("lh3.p2.addr", dm_addr, 32'h8000_000C);
    chk("lh3.rdata", rdata, 32'hFFFF_CDAB);
    $display("split LH 0x8000000B: rdata=%h", rdata);

    // Split LW at off 1.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h4433_2211);
    #1;
    chk_ctl("lw1.p1", 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110);
    @(negedge clk);
    dm_rd = 32'h8877_6655;
    #1;
    chk_ctl("lw1.p2", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
    chk("lw1.p2.addr", dm_addr, 32'h8000_0004);
    chk("lw1.rdata", rdata, 32'h5544_3322);
    $display("split LW 0x80000001: rdata=%h", rdata);

    // Split SW at off 1 aborted by reset during SECOND.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h8000_0001, 32'hAABB_CCDD, 32'h0);
    #1;
    chk_ctl("abort.p1", 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110);
    chk("abort.p1.wd", dm_wd, 32'hBBCC_DD00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_ctl("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("abort.rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h0);
    #1;
    chk_ctl("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b000, 32'h8000_0004, 32'h0000_0077, 32'h0);
    #1;
    chk_ctl("abort.next", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
    chk("abort.next.addr", dm_addr, 32'h8000_0004);
    $display("post-abort SB: done=%b addr=%h be=%b", done, dm_addr, dm_byte_en);

    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter SIZE_POW2, default 9, meaning data memory size is 2^SIZE_POW2 bytes.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of the first data memory location.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req  input  1  MEM-stage load/store request valid.
REQ-006 Port is_store  input  1  1 = store, 0 = load.
REQ-007 Port funct3  input  3  RV32 load/store width code.
REQ-008 Port addr  input  32  effective byte address.
REQ-009 Port wdata  input  32  store data, right-justified.
REQ-010 Port rdata  output  32  load result, aligned and extended.
REQ-011 Port done  output  1  access complete this cycle.
REQ-012 Port stall  output  1  hold the pipeline; the request is still in progress.
REQ-013 Port err  output  1  access fault or illegal funct3 (completes with done=1).
REQ-014 Port dm_we  output  1  data memory write enable.
REQ-015 Port dm_byte_en  output  4  data memory byte enables.
REQ-016 Port dm_addr  output  32  data memory address (always word-aligned).
REQ-017 Port dm_wd  output  32  data memory write data, lane-shifted.
REQ-018 Port dm_rd  input  32  data memory read data (asynchronous, same cycle as dm_addr).

Function
REQ-019 The decoded width SHALL be byte for funct3 000/100, half for 001/101, and word for 010; 100/101 SHALL be zero-extending loads.
REQ-020 An illegal code SHALL assert err=1, done=1, and dm_we=0 in the request cycle; illegal codes are 011, 110, 111, and 100/101 with is_store=1.
REQ-021 The block SHALL define off=addr[1:0] and last=addr+size-1.
REQ-022 An access with addr or last outside [BASE_ADDR, BASE_ADDR+2^SIZE_POW2-1] SHALL assert err=1 and done=1, with dm_we=0, in the request cycle.
REQ-023 An access SHALL be split when off+size>4, which covers half at off 3 and word at off 1, 2 or 3; otherwise it is single.
REQ-024 The FSM SHALL have two states, IDLE and SECOND.
REQ-025 In IDLE with req=1 and no fault, a single access SHALL drive dm_addr={addr[31:2],2'b00}, dm_byte_en=mask(size)<<off, and dm_wd=wdata<<(8*off), with done=1, stall=0, and the state remaining IDLE.
REQ-026 For a single load, rdata SHALL be the extension of (dm_rd>>(8*off)) at the decoded width, valid in the same cycle as done.
REQ-027 In IDLE with req=1 and a split access, the block SHALL issue part 1 at word {addr[31:2],2'b00}, with byte_en=4'b1111<<off and dm_wd=wdata<<(8*off).
REQ-028 During part 1 of a split access, the block SHALL assert stall=1 with done=0, register addr, funct3, is_store and wdata, latch lo=dm_rd>>(8*off), and go to SECOND.
REQ-029 In SECOND, part 2 SHALL use the registered request only, at dm_addr=registered word+4, with dm_byte_en=mask(size)>>(4-off) (low bytes) and dm_wd=wdata>>(8*(4-off)).
REQ-030 In SECOND, the block SHALL assert done=1 and stall=0, and the next state SHALL be IDLE.
REQ-031 For a split load, rdata SHALL be the extension of (lo | dm_rd<<(8*(4-off))) at the decoded width, valid in the SECOND cycle.
REQ-032 In SECOND, req, addr and all other inputs SHALL be ignored; a new request is accepted only in IDLE.
REQ-033 dm_we SHALL equal is_store AND the cycle is an issuing cycle (IDLE&req&no-fault, or SECOND); loads never write.
REQ-034 When not issuing, the block SHALL drive dm_we=0, dm_byte_en=0, done=0 and stall=0; dm_addr and dm_wd are don't-care but SHALL never be X.
REQ-035 A split access SHALL be fault-checked in full in IDLE, so that no part-1 write occurs if part 2 would fault.
REQ-036 All address arithmetic SHALL be 32-bit and wrap modulo 2^32, and a last value that wraps past 32'hFFFF_FFFF SHALL be a fault.

Reset
REQ-037 While rst=1, the block SHALL drive dm_we=0, dm_byte_en=0, done=0, stall=0, err=0 and rdata=0.
REQ-038 On the first rising edge with rst=1, state SHALL be IDLE and lo and all registered request fields SHALL be 0.
REQ-039 A rst asserted in SECOND SHALL abort part 2, so no second write occurs and done is not asserted.
REQ-040 The first request after reset SHALL be accepted in the cycle rst deasserts.

Verification
REQ-041 SW wdata=32'hDEADBEEF at 0x8000_0004 -> one cycle: dm_byte_en=1111, dm_addr=0x8000_0004, dm_wd=DEADBEEF, done=1, stall=0.
REQ-042 LB at 0x8000_0003 with dm_rd=32'h80_12_34_56 -> rdata=32'hFFFF_FF80 same cycle; LBU gives 32'h0000_0080.
REQ-043 SW wdata=32'h11223344 at 0x8000_0006 -> cycle 1: addr 0x8000_0004, be=1100, wd=3344_0000, stall=1; cycle 2: addr 0x8000_0008, be=0011, wd=0000_1122, done=1.
REQ-044 LH at 0x8000_000B with word 0x8000_0008=32'hAB00_0000 and word 0x8000_000C=32'h0000_00CD -> 2 cycles, rdata=32'hFFFF_CDAB.
REQ-045 LW at 0x8000_01FE (last word boundary, SIZE_POW2=9) -> err=1, done=1, dm_we=0, no stall.
REQ-046 Split SW at 0x8000_0001 with rst=1 during SECOND -> only the part-1 write observed, done=0, state IDLE next cycle.
REQ-047 funct3=011 load -> err=1, done=1.
REQ-048 SB with funct3=100 -> err=1, dm_we=0.
